// File: rtl/sample_stream_if.sv
// Handshake bundle between a sample source/host and sample_stream_ctrl.
// master = host/source side, slave = controller side.
interface sample_stream_if #(
  parameter int DW = 22
);
  logic          start;
  logic          stop;
  logic          src_valid;
  logic [DW-1:0] src_data;
  logic          src_last;
  logic          src_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          busy;
  logic          done;
  logic          underrun;

  modport master (
    output start, stop, src_valid, src_data, src_last,
    input  src_ready, out_valid, out_data, busy, done, underrun
  );

  modport slave (
    input  start, stop, src_valid, src_data, src_last,
    output src_ready, out_valid, out_data, busy, done, underrun
  );
endinterface

// File: rtl/sample_stream_ctrl.sv
// Buffers a signed sample stream in a FIFO, prefills, then emits one sample every
// RATE_DIV cycles with underrun/end-of-stream detection. Option: HOLD_ON_UNDERRUN_EN.
module sample_stream_ctrl #(
  parameter int DW       = 22,
  parameter int DEPTH    = 8,
  parameter int PREFILL  = 4,
  parameter int RATE_DIV = 4
) (
  input  logic            clk,
  input  logic            rst,
  sample_stream_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_DONE} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   count_reg;
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic            last_seen_reg;
  logic [RW-1:0]   rate_cnt_reg;
  logic            out_valid_reg;
  logic [DW-1:0]   out_data_reg;
  logic            underrun_reg;
  logic [DW-1:0]   mem [DEPTH];

  logic accepting, push, tick, empty, pop, starve, flush, hold_strobe;
  logic busy_c, done_c;

  // Readiness depends only on registered state so a pop never reaches src_ready.
  assign accepting = ((state_reg == S_FILL) || (state_reg == S_RUN)) &&
                     (count_reg < CW'(DEPTH)) && !last_seen_reg;
  assign push   = bus.src_valid && accepting;
  assign tick   = (state_reg == S_RUN) && (rate_cnt_reg == RW'(RATE_DIV - 1));
  assign empty  = (count_reg == '0);
  assign pop    = tick && !empty;
  assign starve = tick && empty && !last_seen_reg;
  assign flush  = bus.stop || (state_reg == S_DONE);

`ifdef HOLD_ON_UNDERRUN_EN
  assign hold_strobe = starve;
`else
  assign hold_strobe = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    busy_c     = (state_reg != S_IDLE);
    done_c     = (state_reg == S_DONE);
    case (state_reg)
      S_IDLE:  if (bus.start) state_next = S_FILL;
      S_FILL:  if ((count_reg >= CW'(PREFILL)) || last_seen_reg) state_next = S_RUN;
      S_RUN:   if (empty && last_seen_reg) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (bus.stop) state_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= bus.src_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg     <= '0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      last_seen_reg <= 1'b0;
      rate_cnt_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      underrun_reg  <= 1'b0;
    end else begin
      if (flush) begin
        count_reg     <= '0;
        wr_ptr_reg    <= '0;
        rd_ptr_reg    <= '0;
        last_seen_reg <= 1'b0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
        if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
        case ({push, pop})
          2'b10:   count_reg <= count_reg + CW'(1);
          2'b01:   count_reg <= count_reg - CW'(1);
          default: count_reg <= count_reg;
        endcase
        if (push && bus.src_last) last_seen_reg <= 1'b1;
      end

      // Held at zero outside RUN, so the first tick lands RATE_DIV cycles into RUN.
      if (state_reg != S_RUN || tick) rate_cnt_reg <= '0;
      else                            rate_cnt_reg <= rate_cnt_reg + RW'(1);

      out_valid_reg <= !bus.stop && (pop || hold_strobe);
      if (!bus.stop && pop) out_data_reg <= mem[rd_ptr_reg];

      if ((state_reg == S_IDLE) && bus.start && !bus.stop) underrun_reg <= 1'b0;
      else if (starve && !bus.stop)                       underrun_reg <= 1'b1;
    end
  end

  assign bus.src_ready = accepting;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.busy      = busy_c;
  assign bus.done      = done_c;
  assign bus.underrun  = underrun_reg;
endmodule
